// File: rtl/rob_nway_ckpt_pkg.sv
// Shared types for the N-way reorder buffer.
// Latency: n/a (types only).
// Backpressure: n/a (types only).
// ROB_EXCEPT_EN adds a per-entry exception bit to ROB_PACKET.
package rob_nway_ckpt_pkg;

    localparam int ROB_DEPTH = 32;

    // Default-sized index and pointer types; the pointer carries a wrap bit above the index.
    typedef logic [$clog2(ROB_DEPTH)-1:0] ROB_IDX;
    typedef logic [$clog2(ROB_DEPTH):0]   ROB_PTR;

    typedef struct packed {
        logic [31:0] PC;
        logic [4:0]  dest_reg_idx;
        logic        halt;
        logic [5:0]  t;
        logic [5:0]  t_old;
        logic        valid;
        logic        complete;
`ifdef ROB_EXCEPT_EN
        logic        exc;
`endif
    } ROB_PACKET;

endpackage

// File: rtl/rob_nway_ckpt_retire_sel.sv
// Finds the retirable prefix of the R-entry window at the ROB head.
// Latency: combinational.
// Backpressure: none; the count simply stops at the first not-ready entry.
// Ports: ent_valid/ent_complete/ent_stop per window slot ([0] oldest); ret_cnt = prefix length.
// ent_stop marks an entry that retires but ends the group (halt, or exception under ROB_EXCEPT_EN).
module rob_retire_sel #(
    parameter int R = 3,
    localparam int RCW = $clog2(R + 1)
) (
    input  logic [R-1:0]   ent_valid,
    input  logic [R-1:0]   ent_complete,
    input  logic [R-1:0]   ent_stop,
    output logic [RCW-1:0] ret_cnt
);

    logic blocked;

    always_comb begin
        ret_cnt = '0;
        blocked = 1'b0;
        for (int k = 0; k < R; k++) begin
            if (!blocked) begin
                if (ent_valid[k] && ent_complete[k]) begin
                    ret_cnt = ret_cnt + RCW'(1);
                    if (ent_stop[k]) blocked = 1'b1;
                end else begin
                    blocked = 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/rob_nway_ckpt.sv
// N-way reorder buffer with index-addressed completion and single-cycle branch squash.
// Latency: dispatch->entry 1 cycle; complete->retire >= 1 cycle; squash takes effect next cycle.
// Backpressure: disp_space (registered state only, ignores same-cycle retire) bounds disp_cnt.
// Ports: clock/reset (sync, active-high); disp_pkt/disp_cnt -> disp_idx/disp_space;
//        cmp_valid/cmp_idx completion; sq_en/sq_idx squash; ret_pkt/ret_cnt/halted/count out.
// Optional ROB_EXCEPT_EN: adds cmp_exc input and exc_flush output (retire-time full flush).
module rob_nway_ckpt
    import rob_nway_ckpt_pkg::*;
#(
    parameter int DEPTH = 32,
    parameter int N     = 3,
    parameter int C     = 3,
    parameter int R     = 3,
    localparam int IW  = $clog2(DEPTH),
    localparam int NCW = $clog2(N + 1),
    localparam int RCW = $clog2(R + 1)
) (
    input  logic                 clock,
    input  logic                 reset,
    input  ROB_PACKET [N-1:0]    disp_pkt,
    input  logic [NCW-1:0]       disp_cnt,
    output logic [N-1:0][IW-1:0] disp_idx,
    output logic [NCW-1:0]       disp_space,
    input  logic [C-1:0]         cmp_valid,
    input  logic [C-1:0][IW-1:0] cmp_idx,
`ifdef ROB_EXCEPT_EN
    input  logic [C-1:0]         cmp_exc,
    output logic                 exc_flush,
`endif
    input  logic                 sq_en,
    input  logic [IW-1:0]        sq_idx,
    output ROB_PACKET [R-1:0]    ret_pkt,
    output logic [RCW-1:0]       ret_cnt,
    output logic                 halted,
    output logic [IW:0]          count
);

    ROB_PACKET               rob [DEPTH];
    logic [IW:0]             head;
    logic [IW:0]             tail;

    ROB_PACKET [R-1:0]       win;
    logic [R-1:0][IW-1:0]    win_idx;
    logic [R-1:0]            win_valid;
    logic [R-1:0]            win_complete;
    logic [R-1:0]            win_stop;
    logic [RCW-1:0]          sel_cnt;
    logic                    retire_halt;
    logic                    flush_now;

    logic [IW:0]             free_slots;
    logic [IW-1:0]           sq_off;
    logic [IW:0]             sq_tail;
    logic [IW-1:0]           rel_pos [DEPTH];
    logic [DEPTH-1:0]        kill;
    ROB_PACKET [N-1:0]       disp_ent;

    assign count      = tail - head;
    assign free_slots = (IW+1)'(DEPTH) - count;
    assign disp_space = (free_slots >= (IW+1)'(N)) ? NCW'(N) : NCW'(free_slots);

    // Squash: the branch's distance from head gives its full pointer, so the new
    // tail inherits the correct wrap bit without comparing MSBs explicitly.
    assign sq_off  = sq_idx - head[IW-1:0];
    assign sq_tail = head + (IW+1)'(sq_off) + (IW+1)'(1);

    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            rel_pos[i] = IW'(i) - head[IW-1:0];
            kill[i]    = sq_en && (rel_pos[i] > sq_off) && ({1'b0, rel_pos[i]} < count);
        end
    end

    always_comb begin
        for (int j = 0; j < N; j++) begin
            disp_idx[j]          = tail[IW-1:0] + IW'(j);
            disp_ent[j]          = disp_pkt[j];
            disp_ent[j].valid    = 1'b1;
            disp_ent[j].complete = 1'b0;
`ifdef ROB_EXCEPT_EN
            disp_ent[j].exc      = 1'b0;
`endif
        end
    end

    always_comb begin
        for (int k = 0; k < R; k++) begin
            win_idx[k]      = head[IW-1:0] + IW'(k);
            win[k]          = rob[win_idx[k]];
            win_valid[k]    = win[k].valid;
            win_complete[k] = win[k].complete;
            win_stop[k]     = win[k].halt;
`ifdef ROB_EXCEPT_EN
            win_stop[k]     = win[k].halt | win[k].exc;
`endif
        end
    end

    rob_retire_sel #(.R(R)) u_retire_sel (
        .ent_valid    (win_valid),
        .ent_complete (win_complete),
        .ent_stop     (win_stop),
        .ret_cnt      (sel_cnt)
    );

    always_comb begin
        ret_cnt     = halted ? '0 : sel_cnt;
        retire_halt = 1'b0;
        flush_now   = 1'b0;
        for (int k = 0; k < R; k++) begin
            ret_pkt[k] = '0;
            if (RCW'(k) < ret_cnt) begin
                ret_pkt[k]  = win[k];
                retire_halt = retire_halt | win[k].halt;
`ifdef ROB_EXCEPT_EN
                flush_now   = flush_now | win[k].exc;
`endif
            end
        end
    end

`ifdef ROB_EXCEPT_EN
    assign exc_flush = flush_now;
`endif

    // Later writes in this block deliberately override earlier ones:
    // completion < squash kill < dispatch < retire clear < exception flush.
    always_ff @(posedge clock) begin
        if (reset) begin
            head   <= '0;
            tail   <= '0;
            halted <= 1'b0;
            for (int i = 0; i < DEPTH; i++) rob[i] <= '0;
        end else begin
            for (int c = 0; c < C; c++) begin
                if (cmp_valid[c] && rob[cmp_idx[c]].valid && !kill[cmp_idx[c]]) begin
                    rob[cmp_idx[c]].complete <= 1'b1;
`ifdef ROB_EXCEPT_EN
                    rob[cmp_idx[c]].exc      <= cmp_exc[c];
`endif
                end
            end
            for (int i = 0; i < DEPTH; i++) begin
                if (kill[i]) rob[i] <= '0;
            end
            if (!sq_en) begin
                for (int j = 0; j < N; j++) begin
                    if (NCW'(j) < disp_cnt) rob[disp_idx[j]] <= disp_ent[j];
                end
            end
            for (int k = 0; k < R; k++) begin
                if (RCW'(k) < ret_cnt) rob[win_idx[k]] <= '0;
            end
            if (flush_now) begin
                for (int i = 0; i < DEPTH; i++) rob[i] <= '0;
            end

            head   <= head + (IW+1)'(ret_cnt);
            halted <= halted | retire_halt;
            if (flush_now)  tail <= head + (IW+1)'(ret_cnt);
            else if (sq_en) tail <= sq_tail;
            else            tail <= tail + (IW+1)'(disp_cnt);
        end
    end

    a_disp_cnt_legal: assert property (@(posedge clock) disable iff (reset) disp_cnt <= disp_space);

endmodule

// File: tb/tb_rob_nway_ckpt.sv
module tb_rob_nway_ckpt;
    import rob_nway_ckpt_pkg::*;

    localparam int DEPTH = 8;
    localparam int N = 2;
    localparam int C = 2;
    localparam int R = 2;

    logic              clock = 1'b0;
    logic              reset = 1'b1;
    ROB_PACKET [N-1:0] disp_pkt = '0;
    logic [1:0]        disp_cnt = '0;
    logic [N-1:0][2:0] disp_idx;
    logic [1:0]        disp_space;
    logic [C-1:0]      cmp_valid = '0;
    logic [C-1:0][2:0] cmp_idx = '0;
    logic              sq_en = 1'b0;
    logic [2:0]        sq_idx = '0;
    ROB_PACKET [R-1:0] ret_pkt;
    logic [1:0]        ret_cnt;
    logic              halted;
    logic [3:0]        count;
`ifdef ROB_EXCEPT_EN
    logic [C-1:0]      cmp_exc = '0;
    logic              exc_flush;
`endif

    int checks = 0;
    int errors = 0;
    int seq = 0;

    // Model: queue of live entries, oldest first; head index tracked modulo DEPTH.
    ROB_PACKET mq[$];
    int        mhead = 0;
    bit        mhalted = 1'b0;

    always #5 clock = ~clock;

    rob_nway_ckpt #(.DEPTH(DEPTH), .N(N), .C(C), .R(R)) dut (
        .clock      (clock),
        .reset      (reset),
        .disp_pkt   (disp_pkt),
        .disp_cnt   (disp_cnt),
        .disp_idx   (disp_idx),
        .disp_space (disp_space),
        .cmp_valid  (cmp_valid),
        .cmp_idx    (cmp_idx),
`ifdef ROB_EXCEPT_EN
        .cmp_exc    (cmp_exc),
        .exc_flush  (exc_flush),
`endif
        .sq_en      (sq_en),
        .sq_idx     (sq_idx),
        .ret_pkt    (ret_pkt),
        .ret_cnt    (ret_cnt),
        .halted     (halted),
        .count      (count)
    );

    task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    function automatic ROB_PACKET make_pkt(bit h);
        ROB_PACKET p;
        p              = '0;
        p.PC           = 32'h1000 + 32'(seq) * 4;
        p.dest_reg_idx = 5'(seq);
        p.t            = 6'(seq);
        p.t_old        = 6'(seq + 32);
        p.halt         = h;
        p.valid        = 1'b0;   // garbage the DUT must overwrite
        p.complete     = 1'b1;
        seq++;
        return p;
    endfunction

    task automatic idle();
        disp_cnt  = '0;
        disp_pkt  = '0;
        cmp_valid = '0;
        cmp_idx   = '0;
        sq_en     = 1'b0;
        sq_idx    = '0;
`ifdef ROB_EXCEPT_EN
        cmp_exc   = '0;
`endif
    endtask

    // Compare every output against the model, advance the model, then step one clock.
    task automatic cycle();
        int sz, rc, pos;
        bit fl;
        ROB_PACKET e;
        sz = mq.size();
        chk("count", count, sz);
        chk("disp_space", disp_space, (DEPTH - sz < N) ? DEPTH - sz : N);
        for (int j = 0; j < N; j++) chk("disp_idx", disp_idx[j], (mhead + sz + j) % DEPTH);
        rc = 0;
        fl = 1'b0;
        if (!mhalted) begin
            for (int k = 0; k < R && k < sz; k++) begin
                if (!mq[k].complete) break;
                rc++;
                if (mq[k].halt) break;
`ifdef ROB_EXCEPT_EN
                if (mq[k].exc) begin fl = 1'b1; break; end
`endif
            end
        end
        chk("ret_cnt", ret_cnt, rc);
        for (int k = 0; k < R; k++) begin
            e = '0;
            if (k < rc) e = mq[k];
            chk("ret_pkt", ret_pkt[k], e);
        end
        chk("halted", halted, mhalted);
`ifdef ROB_EXCEPT_EN
        chk("exc_flush", exc_flush, fl);
`endif
        for (int c = 0; c < C; c++) begin
            if (cmp_valid[c]) begin
                pos = (int'(cmp_idx[c]) - mhead + DEPTH) % DEPTH;
                if (pos < sz) begin
                    e = mq[pos];
                    e.complete = 1'b1;
`ifdef ROB_EXCEPT_EN
                    e.exc = cmp_exc[c];
`endif
                    mq[pos] = e;
                end
            end
        end
        if (sq_en) begin
            pos = (int'(sq_idx) - mhead + DEPTH) % DEPTH;
            while (mq.size() > pos + 1) void'(mq.pop_back());
        end
        for (int k = 0; k < rc; k++) begin
            if (mq[0].halt) mhalted = 1'b1;
            void'(mq.pop_front());
        end
        mhead = (mhead + rc) % DEPTH;
        if (fl) mq.delete();
        else if (!sq_en) begin
            for (int j = 0; j < int'(disp_cnt); j++) begin
                e = disp_pkt[j];
                e.valid = 1'b1;
                e.complete = 1'b0;
`ifdef ROB_EXCEPT_EN
                e.exc = 1'b0;
`endif
                mq.push_back(e);
            end
        end
        @(posedge clock);
        @(negedge clock);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        @(posedge clock);
        @(negedge clock);
        #1;
        reset = 1'b0;
        idle();
        mq.delete();
        mhead = 0;
        mhalted = 1'b0;
    endtask

    task automatic disp(int n);
        idle();
        disp_cnt = 2'(n);
        for (int j = 0; j < n; j++) disp_pkt[j] = make_pkt(1'b0);
        cycle();
    endtask

    task automatic comp(int a, int b);
        idle();
        if (a >= 0) begin cmp_valid[0] = 1'b1; cmp_idx[0] = 3'(a); end
        if (b >= 0) begin cmp_valid[1] = 1'b1; cmp_idx[1] = 3'(b); end
        cycle();
    endtask

    task automatic tick();
        idle();
        cycle();
    endtask

    initial begin
        idle();
        @(negedge clock);
        #1;
        do_reset();
        chk("rst_count", count, 0);
        chk("rst_ret_cnt", ret_cnt, 0);
        chk("rst_halted", halted, 0);
        chk("rst_space", disp_space, 2);
        chk("rst_ret_pkt", ret_pkt[0], 0);

        // Fill
        for (int i = 0; i < 4; i++) begin
            chk("fill_idx0", disp_idx[0], 2 * i);
            chk("fill_idx1", disp_idx[1], 2 * i + 1);
            disp(2);
        end
        chk("fill_count", count, 8);
        chk("fill_space", disp_space, 0);

        // Out-of-order completion
        comp(1, -1);
        chk("ooo_wait", ret_cnt, 0);
        comp(0, -1);
        chk("ooo_ret", ret_cnt, 2);
        chk("ooo_pc0", ret_pkt[0].PC, 32'h1000);
        chk("ooo_pc1", ret_pkt[1].PC, 32'h1004);
        tick();
        chk("ooo_count", count, 6);

        // Drain, then walk the head round to index 6 of the second lap
        comp(2, 3);
        comp(4, 5);
        comp(6, 7);
        tick();
        chk("drain_count", count, 0);
        disp(2); disp(2); disp(2);
        comp(0, 1); comp(2, 3); comp(4, 5);
        tick();
        chk("wrap_count", count, 0);
        chk("wrap_idx0", disp_idx[0], 6);
        chk("wrap_idx1", disp_idx[1], 7);
        disp(2);
        comp(6, 7);
        tick();
        chk("wrap_next0", disp_idx[0], 0);
        chk("wrap_next1", disp_idx[1], 1);
        disp(2);
        chk("wrap_count2", count, 2);

        // Squash, entered through a reset that must override live inputs
        idle();
        disp_cnt = 2'd2;
        cmp_valid = 2'b11;
        do_reset();
        chk("midrst_count", count, 0);
        disp(2); disp(2); disp(2); disp(1);
        comp(0, 1);
        tick();
        chk("sq_pre_count", count, 5);
        idle();
        sq_en = 1'b1;
        sq_idx = 3'd3;
        disp_cnt = 2'd2;
        disp_pkt[0] = make_pkt(1'b0);
        disp_pkt[1] = make_pkt(1'b0);
        cmp_valid[0] = 1'b1;
        cmp_idx[0] = 3'd5;
        cycle();
        chk("sq_count", count, 2);
        chk("sq_tail_idx", disp_idx[0], 4);
        comp(2, 3);
        comp(5, 4);
        tick();
        chk("sq_drop_count", count, 0);
        chk("sq_drop_ret", ret_cnt, 0);
        disp(2);
        idle();
        sq_en = 1'b1;
        sq_idx = 3'd5;
        cycle();
        chk("sq_youngest_count", count, 2);

        // Halt
        do_reset();
        idle();
        disp_cnt = 2'd2;
        disp_pkt[0] = make_pkt(1'b1);
        disp_pkt[1] = make_pkt(1'b0);
        cycle();
        comp(0, 1);
        chk("halt_ret", ret_cnt, 1);
        chk("halt_flag_pkt", ret_pkt[0].halt, 1);
        tick();
        chk("halted", halted, 1);
        chk("halt_count", count, 1);
        repeat (3) tick();
        chk("halt_stuck", ret_cnt, 0);
        chk("halt_count2", count, 1);

`ifdef ROB_EXCEPT_EN
        do_reset();
        disp(2);
        idle();
        cmp_valid[0] = 1'b1;
        cmp_idx[0] = 3'd0;
        cmp_exc[0] = 1'b1;
        cycle();
        chk("exc_ret", ret_cnt, 1);
        chk("exc_flush", exc_flush, 1);
        tick();
        chk("exc_count", count, 0);
        chk("exc_flush_drop", exc_flush, 0);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
